// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the serial adder.
//   - state_e      : controller states (IDLE, BUSY, DONE), 2 bits.
//   - cnt_width(n) : width of a beat counter that counts 0..n without wrapping.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // One extra bit over $clog2(n) so the counter can reach n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder
//   Combinational ripple adder of DIGIT full-adder cells.
//   Ports:
//     a, b    [DIGIT-1:0] in  : operand digits
//     cin             in      : carry into bit 0
//     sum     [DIGIT-1:0] out : digit sum
//     cout            out     : carry out of bit DIGIT-1
//     c_top           out     : carry into bit DIGIT-1 (for signed overflow)
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_full_adder
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    assign cout  = carry[DIGIT];
    assign c_top = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
//   per clock, over N = WIDTH/DIGIT beats.
//   Optional feature macro: SERIAL_ADDER_SUB_EN adds a 'sub' input; with
//   sub=1 the block computes a - b - cin (cout = inverted borrow).
//
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. in_ready is high only in IDLE, out_valid only in DONE, so an input
//   and an output transfer never share a cycle.
//
//   Ports:
//     clk, rst_n         : clock, asynchronous active-low reset
//     in_valid/in_ready  : operand handshake
//     a, b [WIDTH-1:0]   : operands
//     cin                : carry-in
//     sub                : (SERIAL_ADDER_SUB_EN only) subtract select
//     out_valid/out_ready: result handshake
//     sum [WIDTH-1:0]    : result, held until the next operation completes
//     cout               : carry out of the MSB
//     overflow           : two's-complement overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_adder: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // sum shift register, filled from the top
    logic [WIDTH-1:0] sum_q, sum_d;     // visible result, updated only on completion
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Subtraction is folded in at capture time: b is stored inverted and the
    // carry register starts at ~cin, so the datapath itself only ever adds.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
`ifdef SERIAL_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_c_top;

    digit_adder #(
        .DIGIT(DIGIT)
    ) u_digit_adder (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .sum  (dig_sum),
        .cout (dig_cout),
        .c_top(dig_c_top)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                acc_d = acc_q >> DIGIT;
                acc_d[WIDTH-1 -: DIGIT] = dig_sum;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Last beat: the digit adder is working on the MSB digit.
                    sum_d   = acc_d;
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ dig_c_top;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder that adds two WIDTH-bit operands plus carry-in over WIDTH/DIGIT clock cycles, DIGIT bits per cycle. It uses a small ripple adder of full-adder cells and a shift register. It sits behind a valid/ready handshake on each side, so datapath blocks can trade latency for area in place of a full-width combinational ripple adder. It outputs sum, carry-out and signed overflow.

## Interface

Parameters:
- WIDTH, 32, operand and sum width in bits.
- DIGIT, 4, bits added per cycle. Must divide WIDTH; otherwise elaboration fails with $error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset. Asynchronous, active-low.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out of the MSB.
- overflow  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

## Operation

- Derived constant: N = WIDTH/DIGIT beats.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch a, b and cin into registers, clear the beat counter, and go to BUSY.
  - BUSY: each cycle, add the low DIGIT bits of the A and B shift registers plus the carry register.
    - Shift both operand registers right by DIGIT.
    - Shift the digit sum into the top of the sum register.
    - Update the carry register and the beat counter.
    - After beat N-1, capture cout and overflow (overflow uses the carry into bit DIGIT-1 of the final digit), then go to DONE.
  - DONE: out_valid=1. sum, cout and overflow stay stable. On out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. in_valid in those states is ignored and has no side effects.
- A new input is never accepted in the same cycle as an output handshake; IDLE is always visited for at least one cycle.
- DIGIT == WIDTH is legal: N=1 and BUSY lasts one cycle.
- Beat counter width is $clog2(N)+1. No wrap-around is possible.
- Reset (asynchronous, at any time including mid-BUSY):
  - Return to IDLE.
  - Zero all registers.
  - Outputs become in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
  - The in-flight operation is discarded.

## Timing

- Input handshake in cycle 0 (IDLE, in_valid=1).
- BUSY occupies cycles 1..N. out_valid rises after the edge ending cycle N, i.e. it is visible in cycle N+1.
- Latency from input handshake to out_valid is N+1 cycles.
- Minimum initiation interval is N+2 cycles (DONE with out_ready=1, then one IDLE cycle).
- Outputs are registered only. There is no combinational path from in_valid or out_ready to any output except through state.
- sum, cout and overflow hold their values until the next accepted operation completes; they are not cleared on leaving DONE.

## Configuration

- Macro SERIAL_ADDER_SUB_EN.
- Defined: adds input port sub (1 bit), latched at the input handshake together with the operands.
  - With sub=1 the block computes a - b - cin: operand B is inverted and the effective carry-in is ~cin.
  - cout is then the inverted borrow (1 = no borrow).
  - overflow is signed subtraction overflow.
- Undefined: no sub port; the block always adds.

## Structure

- Package serial_adder_pkg holds:
  - the state enum typedef (IDLE, BUSY, DONE), 2 bits;
  - a helper function for the beat-counter width.
- Sub-module digit_adder (parameter DIGIT):
  - combinational ripple chain of DIGIT full_adder cells;
  - outputs the digit sum, the carry-out, and the carry into the top bit (used for overflow).
- The top level holds the FSM, the operand, sum and carry registers, and the counter.

## Test plan

All scenarios use WIDTH=8, DIGIT=4 (N=2) unless noted.

- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; out_valid visible exactly 3 cycles after the input handshake.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. a=0x80, b=0xFF, cin=1 -> sum=0x80, cout=1, overflow=0.
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout and overflow stay stable, and in_ready=0;
  - in_valid pulses during BUSY and DONE are ignored.
- Reset mid-operation: drop rst_n in the first BUSY cycle -> in_ready=1, out_valid=0 and sum=0 immediately (asynchronous); the next operation a=0x12, b=0x34 gives sum=0x46.
- Configuration and width:
  - with SERIAL_ADDER_SUB_EN, a=0x05, b=0x07, sub=1, cin=0 -> sum=0xFE, cout=0;
  - with WIDTH=8, DIGIT=8, a=0x10, b=0x20 -> sum=0x30, latency 2 cycles.
- Random regression: 10k random operands per configuration (DIGIT=1, 2, 4, 8) with random handshake stalls, compared against {cout, sum} = a + b + cin.
